// File: rtl/mem_responder.sv
// Data-memory responder: one load/store at a time, done pulse LATENCY cycles after accept.
// Backpressure: busy stays high from accept until the end of done; req is ignored while busy.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic [1:0]     size_q, size_d;
    logic           sext_q, sext_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           mis_q, mis_d;
    logic [31:0]    rdata_q, rdata_d;

    logic [31:0]    mem_q [DEPTH_WORDS];

    // Upper address bits only alias the array; they are intentionally dropped.
    logic           unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    // With LATENCY=1 the response is formed straight from the inputs at accept,
    // otherwise from the latched request.
    logic           in_idle;
    logic           cur_wr;
    logic [1:0]     cur_size;
    logic           cur_sext;
    logic [AW+1:0]  cur_addr;
    logic [31:0]    cur_word;
    logic [31:0]    lane_w;
    logic           mis_c;
    logic [31:0]    load_c;
    logic [31:0]    resp_rdata;

    assign in_idle  = (state_q == S_IDLE);
    assign cur_wr   = in_idle ? wr            : wr_q;
    assign cur_size = in_idle ? size          : size_q;
    assign cur_sext = in_idle ? sign_ext      : sext_q;
    assign cur_addr = in_idle ? addr[AW+1:0]  : addr_q;
    assign cur_word = mem_q[cur_addr[AW+1:2]];
    assign lane_w   = cur_word >> {cur_addr[1:0], 3'b000};

    always_comb begin
        mis_c = 1'b0;
        case (cur_size)
            2'b00:   mis_c = 1'b0;
            2'b01:   mis_c = cur_addr[0];
            2'b10:   mis_c = |cur_addr[1:0];
            default: mis_c = 1'b1;
        endcase
    end

    always_comb begin
        load_c = cur_word;
        case (cur_size)
            2'b00:   load_c = cur_sext ? {{24{lane_w[7]}}, lane_w[7:0]}
                                       : {24'h0, lane_w[7:0]};
            2'b01:   load_c = cur_sext ? {{16{lane_w[15]}}, lane_w[15:0]}
                                       : {16'h0, lane_w[15:0]};
            default: load_c = cur_word;
        endcase
    end

    assign resp_rdata = (mis_c || cur_wr) ? 32'h0 : load_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    busy_d  = 1'b1;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        mis_d   = mis_c;
                        rdata_d = resp_rdata;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    mis_d   = mis_c;
                    rdata_d = resp_rdata;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // Store commits at the edge ending RESP, so a following load sees it.
    logic        mem_we;
    logic [31:0] st_word;

    assign mem_we = (state_q == S_RESP) && wr_q && !mis_c;

    always_comb begin
        st_word = cur_word;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    st_word[7:0]   = wdata_q[7:0];
                    2'd1:    st_word[15:8]  = wdata_q[7:0];
                    2'd2:    st_word[23:16] = wdata_q[7:0];
                    default: st_word[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
                else           st_word[15:0]  = wdata_q[15:0];
            end
            default: st_word = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q[AW+1:2]] <= st_word;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign misalign = mis_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_WORDS=256, LATENCY=2); outputs sampled on negedge.
module tb_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misalign;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its done; lat = negedges after accept.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic mi);
        lat = -1;
        rd  = 32'hxxxxxxxx;
        mi  = 1'bx;
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sign_ext = se; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                rd  = rdata;
                mi  = misalign;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
        reset = 1'b0;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic mi;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, mi);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL store_latency got %0d want %0d", lat, LAT); end
        checks++; if (rd !== 32'h0 || mi !== 1'b0) begin errors++; $display("FAIL store_resp got rdata=%h mis=%b want 0/0", rd, mi); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL load_latency got %0d want %0d", lat, LAT); end
        checks++; if (rd !== 32'hDEADBEEF || mi !== 1'b0) begin errors++; $display("FAIL load_word got %h mis=%b want deadbeef/0", rd, mi); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got done=%b rdata=%h want 0/deadbeef", done, rdata); end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic mi;
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte13_sext got %h want ffffffde", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL byte10_zext got %h want 000000ef", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL half12_sext got %h want ffffdead", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL half10_zext got %h want 0000beef", rd); end
    endtask

    task automatic test_partial();
        int lat; logic [31:0] rd; logic mi;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, rd, mi);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL partial_byte got %h want dead55ef", rd); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic mi;
        do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, mi);
        checks++; if (lat !== LAT || mi !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_half got lat=%0d mis=%b rdata=%h want %0d/1/0", lat, mi, rd, LAT); end
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, lat, rd, mi);
        checks++; if (lat !== LAT || mi !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_word_store got lat=%0d mis=%b rdata=%h want %0d/1/0", lat, mi, rd, LAT); end
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (lat !== LAT || mi !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_size11 got lat=%0d mis=%b rdata=%h want %0d/1/0", lat, mi, rd, LAT); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'hDEAD55EF || mi !== 1'b0) begin errors++; $display("FAIL mis_no_side_effect got %h mis=%b want dead55ef/0", rd, mi); end
    endtask

    task automatic test_wrap_busy();
        int dones = 0;
        int lat; logic [31:0] rd; logic mi;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h400; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b want 1", busy); end
        req = 1'b1; wr = 1'b0; addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            if (i == 1) req = 1'b0;
            @(negedge clk);
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL busy_ignore got %0d dones want 1", dones); end
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_load got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int lat; logic [31:0] rd; logic mi;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h11111111;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got busy=%b done=%b want 0/0", busy, done); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL reset_mid_done got %0d dones want 0", dones); end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, mi);
        checks++; if (lat !== LAT || rd !== 32'h0) begin errors++; $display("FAIL reset_mid_load got lat=%0d rdata=%h want %0d/0", lat, rd, LAT); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mi);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_clears_mem got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_partial();
        test_misalign();
        test_wrap_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
